// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared UART state encoding and line constants (rev 1.0)
// ------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_baud_gen : bit-period counter emitting one tick per serial bit (rev 1.0)
// ------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign bit_tick = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter, LSB first, optional even parity (rev 1.0)
// ------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam bit HAS_PARITY = (PARITY_EN != 0);

  uart_state_e          state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 parity, parity_next;
  logic                 tx_next, busy_next, done_next;
  logic                 accept;
  logic                 bit_tick;

  assign accept = (state == ST_IDLE) && wr_en;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable && (state != ST_IDLE)),
    .clear   (enable && accept),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      parity  <= 1'b0;
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else if (enable) begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      parity  <= parity_next;
      tx      <= tx_next;
      busy    <= busy_next;
      tx_done <= done_next;
    end
  end

  // tx is registered, so each bit boundary loads the level of the bit that follows it.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    parity_next  = parity;
    tx_next      = tx;
    busy_next    = busy;
    done_next    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tx_next = IDLE_LEVEL;
        if (accept) begin
          shift_next   = tx_data;
          parity_next  = ^tx_data;
          bit_idx_next = '0;
          busy_next    = 1'b1;
          tx_next      = 1'b0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          tx_next    = shift[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
            tx_next    = HAS_PARITY ? parity : IDLE_LEVEL;
          end else begin
            tx_next = shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          tx_next    = IDLE_LEVEL;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          tx_next    = IDLE_LEVEL;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_tx : scoreboard bench for a plain and an even-parity transmitter (rev 1.0)
// ------------------------------------------------------------------
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst     [2];
  logic       enable  [2];
  logic       wr_en   [2];
  logic [7:0] tx_data [2];
  logic       tx      [2];
  logic       busy    [2];
  logic       tx_done [2];

  logic [7:0] exp_q [2][$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level at bit position pos of a frame carrying d: start, D0..D7, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] d, input int pos, input int par);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (par != 0 && pos == 9) return ^d;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int F = (10 + g) * C;

    uart_tx #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   (g)
    ) u_dut (
      .clk    (clk),
      .rst    (rst[g]),
      .enable (enable[g]),
      .wr_en  (wr_en[g]),
      .tx_data(tx_data[g]),
      .tx     (tx[g]),
      .busy   (busy[g]),
      .tx_done(tx_done[g])
    );

    // Monitor: pops the expected byte when busy rises and follows the frame in enabled cycles.
    initial begin : mon
      bit         active    = 1'b0;
      bit         prev_busy = 1'b0;
      bit         en_s;
      bit         rst_s;
      int         e         = 0;
      logic [7:0] cur       = 8'h00;
      forever begin
        @(posedge clk);
        en_s  = enable[g];
        rst_s = rst[g];
        #1;
        if (rst_s) begin
          active = 1'b0;
          check($sformatf("dut%0d reset_tx", g), int'(tx[g]), 1);
          check($sformatf("dut%0d reset_busy", g), int'(busy[g]), 0);
          check($sformatf("dut%0d reset_done", g), int'(tx_done[g]), 0);
        end else begin
          if (active && en_s) begin
            if (e == F) active = 1'b0;
            else e++;
          end
          if (active) begin
            check($sformatf("dut%0d tx byte=%02h e=%0d", g, cur, e), int'(tx[g]),
                  int'(frame_bit(cur, e / C, g)));
            check($sformatf("dut%0d busy e=%0d", g, e), int'(busy[g]), int'(e < F));
            check($sformatf("dut%0d done e=%0d", g, e), int'(tx_done[g]), int'(e == F));
          end else if (busy[g] === 1'b1 && !prev_busy) begin
            check($sformatf("dut%0d accept_expected", g), int'(exp_q[g].size() > 0), 1);
            cur    = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : 8'h00;
            active = 1'b1;
            e      = 0;
            check($sformatf("dut%0d start_bit", g), int'(tx[g]), 0);
          end else begin
            check($sformatf("dut%0d idle_tx", g), int'(tx[g]), 1);
            check($sformatf("dut%0d idle_busy", g), int'(busy[g]), 0);
            check($sformatf("dut%0d idle_done", g), int'(tx_done[g]), 0);
          end
        end
        prev_busy = busy[g];
      end
    end
  end

  task automatic wait_idle(input int k, input bit rand_en);
    int n = 0;
    while (busy[k] !== 1'b0 && n < 2000) begin
      enable[k] = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end
    enable[k] = 1'b1;
    check($sformatf("dut%0d idle_reached", k), int'(n < 2000), 1);
  endtask

  task automatic send(input int k, input logic [7:0] d);
    wait_idle(k, 1'b0);
    enable[k]  = 1'b1;
    wr_en[k]   = 1'b1;
    tx_data[k] = d;
    exp_q[k].push_back(d);
    @(negedge clk);
    wr_en[k]   = 1'b0;
    tx_data[k] = 8'($urandom);
  endtask

  task automatic measure(input int k, output int m);
    m = 0;
    while (busy[k] !== 1'b0 && m < 1000) begin
      @(negedge clk);
      m++;
    end
  endtask

  initial begin
    int   m;
    int   n;
    int   dcnt;
    int   f;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; enable[k] = 1'b1; wr_en[k] = 1'b0; tx_data[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) rst[k] = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      f = (10 + k) * C;

      send(k, 8'hA5);
      measure(k, m);
      check($sformatf("dut%0d frame_len_a5", k), m, f);
      send(k, 8'h01);
      measure(k, m);
      check($sformatf("dut%0d frame_len_01", k), m, f);

      // Back-to-back with wr_en held high and tx_data scrambled mid-frame.
      wait_idle(k, 1'b0);
      wr_en[k]   = 1'b1;
      tx_data[k] = 8'h3C;
      exp_q[k].push_back(8'h3C);
      exp_q[k].push_back(8'hC3);
      @(negedge clk);
      n = 0;
      while (tx_done[k] !== 1'b1 && n < 200) begin
        tx_data[k] = 8'($urandom);
        @(negedge clk);
        n++;
      end
      check($sformatf("dut%0d b2b_first_len", k), n, f);
      tx_data[k] = 8'hC3;
      @(posedge clk);
      #1;
      check($sformatf("dut%0d b2b_restart_busy", k), int'(busy[k]), 1);
      check($sformatf("dut%0d b2b_restart_tx", k), int'(tx[k]), 0);
      @(negedge clk);
      wr_en[k]   = 1'b0;
      tx_data[k] = 8'($urandom);
      wait_idle(k, 1'b0);

      // Seven-cycle enable stall in the middle of D3.
      send(k, 8'h55);
      repeat (4 * C + 2) @(negedge clk);
      enable[k] = 1'b0;
      repeat (7) @(negedge clk);
      check($sformatf("dut%0d stall_hold_tx", k), int'(tx[k]), int'(frame_bit(8'h55, 4, k)));
      enable[k] = 1'b1;
      m = 4 * C + 2 + 7;
      while (busy[k] !== 1'b0 && m < 500) begin
        @(negedge clk);
        m++;
      end
      check($sformatf("dut%0d stall_len", k), m, f + 7);

      // Reset during D5 abandons the frame.
      send(k, 8'($urandom));
      repeat (6 * C + 1) @(negedge clk);
      rst[k] = 1'b1;
      @(negedge clk);
      rst[k] = 1'b0;
      check($sformatf("dut%0d abort_tx", k), int'(tx[k]), 1);
      check($sformatf("dut%0d abort_busy", k), int'(busy[k]), 0);
      dcnt = 0;
      repeat (f) begin
        @(negedge clk);
        if (tx_done[k] === 1'b1) dcnt++;
      end
      check($sformatf("dut%0d abort_no_done", k), dcnt, 0);
      send(k, 8'h12);
      measure(k, m);
      check($sformatf("dut%0d frame_len_12", k), m, f);

      // Request while disabled in IDLE is not taken.
      enable[k]  = 1'b0;
      wr_en[k]   = 1'b1;
      tx_data[k] = 8'h77;
      repeat (5) @(negedge clk);
      check($sformatf("dut%0d dis_busy", k), int'(busy[k]), 0);
      check($sformatf("dut%0d dis_tx", k), int'(tx[k]), 1);
      wr_en[k] = 1'b0;
      @(negedge clk);
      enable[k] = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("dut%0d dis_after_busy", k), int'(busy[k]), 0);

      // Random bytes with random enable dropouts and idle gaps.
      repeat (8) begin
        send(k, 8'($urandom));
        wait_idle(k, 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("dut%0d queue_empty", k), exp_q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
